// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchroniser, mid-bit sampling FSM,
// one-cycle ready/frameError pulses and a registered busy flag.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] dataOut,
   output logic       ready,
   output logic       frameError,
   output logic       busy
);

   localparam int          HALF      = CLKS_PER_BIT / 2;
   localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        ready_q, ready_d;
   logic        ferr_q, ferr_d;
   logic        busy_q, busy_d;
   logic [1:0]  sync_q;
   logic        rx_sync;

   assign rx_sync = sync_q[1];

   // NOTE: state uses non-blocking assignments under an async reset so every
   // flop, including the shift register and synchroniser, has a defined value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   // NOTE: every comb output is defaulted first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      busy_d  = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_sync) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_sync;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            // Leave at mid-stop-bit so an immediately following start bit is seen.
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_sync) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dataOut    = data_q;
   assign ready      = ready_q;
   assign frameError = ferr_q;
   assign busy       = busy_q;

endmodule
